// File: rtl/chacha_block_seq.sv
// Sequential ChaCha block engine: one quarter-round op per cycle, feed-forward add.
// Optional CHACHA_BLOCK_CTR_INC_EN adds in_next to rerun the stored state with word 12 + 1.
module chacha_block_seq #(
  parameter int ROUNDS = 20
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
`ifdef CHACHA_BLOCK_CTR_INC_EN
  input  logic         in_next,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         busy
);

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_block_seq: ROUNDS must be 8, 12 or 20");
  end

  localparam logic [3:0] LAST_DR = 4'(ROUNDS / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_DONE
  } state_e;

  function automatic logic [31:0] rotl(
    input logic [31:0] v,
    input int unsigned n
  );
    return (v << n) | (v >> (32 - n));
  endfunction

  state_e       state_q, state_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [31:0]  x_q [16];
  logic [31:0]  x_d [16];
  logic [31:0]  t_hi_q, t_hi_d;
  logic [31:0]  t_lo_q, t_lo_d;
  logic [1:0]   op_q, op_d;
  logic [2:0]   qr_q, qr_d;
  logic [3:0]   dr_q, dr_d;
  logic [511:0] ob_q, ob_d;
  logic         armed_q;

  logic [3:0]   sel_a, sel_b, sel_c, sel_d;
  logic [31:0]  wa, wb, wc, wd;
  logic         run, op_bd, op_ad, op_bc;
  logic [31:0]  bd_a, bd_d, bd_c, bd_b;
  logic [31:0]  ad_a, ad_na, ad_nd;
  logic [31:0]  bc_nc, bc_nb;

  assign run       = (state_q == S_RUN);
  assign op_bd     = run && (op_q == 2'd0);
  assign op_ad     = run && (op_q == 2'd1);
  assign op_bc     = run && (op_q == 2'd2);
  assign in_ready  = armed_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = run || (state_q == S_FIN);
  assign out_block = ob_q;

  always_comb begin
    sel_a = 4'd0;
    sel_b = 4'd4;
    sel_c = 4'd8;
    sel_d = 4'd12;
    unique case (qr_q)
      3'd0: begin sel_a = 4'd0; sel_b = 4'd4; sel_c = 4'd8;  sel_d = 4'd12; end
      3'd1: begin sel_a = 4'd1; sel_b = 4'd5; sel_c = 4'd9;  sel_d = 4'd13; end
      3'd2: begin sel_a = 4'd2; sel_b = 4'd6; sel_c = 4'd10; sel_d = 4'd14; end
      3'd3: begin sel_a = 4'd3; sel_b = 4'd7; sel_c = 4'd11; sel_d = 4'd15; end
      3'd4: begin sel_a = 4'd0; sel_b = 4'd5; sel_c = 4'd10; sel_d = 4'd15; end
      3'd5: begin sel_a = 4'd1; sel_b = 4'd6; sel_c = 4'd11; sel_d = 4'd12; end
      3'd6: begin sel_a = 4'd2; sel_b = 4'd7; sel_c = 4'd8;  sel_d = 4'd13; end
      3'd7: begin sel_a = 4'd3; sel_b = 4'd4; sel_c = 4'd9;  sel_d = 4'd14; end
      default: ;
    endcase
  end

  assign wa = w_q[sel_a];
  assign wb = w_q[sel_b];
  assign wc = w_q[sel_c];
  assign wd = w_q[sel_d];

  // bd: first half-round -> {b', d'}
  assign bd_a = wa + wb;
  assign bd_d = rotl(wd ^ bd_a, 16);
  assign bd_c = wc + bd_d;
  assign bd_b = rotl(wb ^ bd_c, 12);

  // ad: a+b is recovered from d' and the original d
  assign ad_a  = {t_lo_q[15:0], t_lo_q[31:16]} ^ wd;
  assign ad_na = ad_a + t_hi_q;
  assign ad_nd = rotl(t_lo_q ^ ad_na, 8);

  // bc: W[d] already holds d'' here, T still holds {b', d'}
  assign bc_nc = wc + t_lo_q + wd;
  assign bc_nb = rotl(t_hi_q ^ bc_nc, 7);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    x_d     = x_q;
    t_hi_d  = t_hi_q;
    t_lo_d  = t_lo_q;
    op_d    = op_q;
    qr_d    = qr_q;
    dr_d    = dr_q;
    ob_d    = ob_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < 16; i++) begin
            x_d[i] = in_state[32*i +: 32];
            w_d[i] = in_state[32*i +: 32];
          end
          op_d    = 2'd0;
          qr_d    = 3'd0;
          dr_d    = 4'd0;
          state_d = S_RUN;
        end
`ifdef CHACHA_BLOCK_CTR_INC_EN
        else if (in_next && in_ready) begin
          x_d[12] = x_q[12] + 32'd1;
          w_d     = x_d;
          op_d    = 2'd0;
          qr_d    = 3'd0;
          dr_d    = 4'd0;
          state_d = S_RUN;
        end
`endif
      end
      S_RUN: begin
        unique case (1'b1)
          op_bd: begin
            t_hi_d = bd_b;
            t_lo_d = bd_d;
          end
          op_ad: begin
            w_d[sel_a] = ad_na;
            w_d[sel_d] = ad_nd;
          end
          op_bc: begin
            w_d[sel_b] = bc_nb;
            w_d[sel_c] = bc_nc;
          end
          default: ;
        endcase
        if (op_q == 2'd2) begin
          op_d = 2'd0;
          qr_d = qr_q + 3'd1;
          if (qr_q == 3'd7) begin
            dr_d = dr_q + 4'd1;
            if (dr_q == LAST_DR) state_d = S_FIN;
          end
        end else begin
          op_d = op_q + 2'd1;
        end
      end
      S_FIN: begin
        for (int i = 0; i < 16; i++) begin
          ob_d[32*i +: 32] = w_q[i] + x_q[i];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      w_q     <= '{default: '0};
      x_q     <= '{default: '0};
      t_hi_q  <= '0;
      t_lo_q  <= '0;
      op_q    <= '0;
      qr_q    <= '0;
      dr_q    <= '0;
      ob_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      x_q     <= x_d;
      t_hi_q  <= t_hi_d;
      t_lo_q  <= t_lo_d;
      op_q    <= op_d;
      qr_q    <= qr_d;
      dr_q    <= dr_d;
      ob_q    <= ob_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chacha_block_seq.sv
// Bench for chacha_block_seq: RFC vector, random states vs a plain ChaCha model,
// backpressure, mid-run reset, ignored input, throughput, optional counter step.
module tb_chacha_block_seq;

  localparam int ROUNDS = 20;
  localparam int LAT    = ROUNDS * 12 + 2;
  localparam int PERIOD = ROUNDS * 12 + 3;

  logic         g_clk = 1'b0;
  logic         g_resetn;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         busy;
`ifdef CHACHA_BLOCK_CTR_INC_EN
  logic         in_next;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [511:0] rfc_state;

  always #5 g_clk = ~g_clk;

  chacha_block_seq #(.ROUNDS(ROUNDS)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef CHACHA_BLOCK_CTR_INC_EN
    .in_next   (in_next),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Textbook ChaCha block: column/diagonal rounds then add the input back.
  function automatic logic [511:0] ref_block(input logic [511:0] s);
    logic [31:0] x [16];
    logic [31:0] w [16];
    int qi [8][4];
    logic [511:0] r;
    int a, b, c, d;
    qi = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
           '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    for (int i = 0; i < 16; i++) begin
      x[i] = s[32*i +: 32];
      w[i] = x[i];
    end
    for (int rd = 0; rd < ROUNDS / 2; rd++) begin
      for (int k = 0; k < 8; k++) begin
        a = qi[k][0]; b = qi[k][1]; c = qi[k][2]; d = qi[k][3];
        w[a] = w[a] + w[b]; w[d] = rl(w[d] ^ w[a], 16);
        w[c] = w[c] + w[d]; w[b] = rl(w[b] ^ w[c], 12);
        w[a] = w[a] + w[b]; w[d] = rl(w[d] ^ w[a], 8);
        w[c] = w[c] + w[d]; w[b] = rl(w[b] ^ w[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + x[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [511:0] with_ctr(input logic [511:0] s, input logic [31:0] c);
    logic [511:0] r;
    r = s;
    r[32*12 +: 32] = c;
    return r;
  endfunction

  // Offer a state; lat counts edges with the accepting edge as 1.
  task automatic send(input logic [511:0] s, output int lat);
    int n;
    n = 0;
    @(negedge g_clk);
    while (!in_ready && n < 2000) begin
      @(negedge g_clk);
      n++;
    end
    in_state = s;
    in_valid = 1'b1;
    @(posedge g_clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(posedge g_clk);
      #1 lat++;
    end
  endtask

  task automatic take(output logic [511:0] b);
    b = out_block;
    @(negedge g_clk);
    out_ready = 1'b1;
    @(posedge g_clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn  = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
`ifdef CHACHA_BLOCK_CTR_INC_EN
    in_next   = 1'b0;
`endif
    repeat (2) @(posedge g_clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    n_cmp++;
    if (out_block !== '0) begin
      n_bad++; $display("FAIL reset_out_block got %h exp 0", out_block);
    end
    @(negedge g_clk) g_resetn = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_rfc();
    int lat;
    logic [511:0] b;
    send(rfc_state, lat);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++; $display("FAIL rfc_latency got %0d exp %0d", lat, LAT);
    end
    take(b);
    n_cmp++;
    if (b[31:0] !== 32'he4e7f110) begin
      n_bad++; $display("FAIL rfc_word0 got %h exp e4e7f110", b[31:0]);
    end
    n_cmp++;
    if (b[511:480] !== 32'h4e3c50a2) begin
      n_bad++; $display("FAIL rfc_word15 got %h exp 4e3c50a2", b[511:480]);
    end
    n_cmp++;
    if (b !== ref_block(rfc_state)) begin
      n_bad++; $display("FAIL rfc_block got %h exp %h", b, ref_block(rfc_state));
    end
  endtask

  task automatic test_random();
    int lat;
    logic [511:0] s, b, e;
    for (int k = 0; k < 4; k++) begin
      s = rand_state();
      e = ref_block(s);
      send(s, lat);
      n_cmp++;
      if (lat !== LAT) begin
        n_bad++; $display("FAIL rand_latency got %0d exp %0d", lat, LAT);
      end
      take(b);
      n_cmp++;
      if (b !== e) begin
        n_bad++; $display("FAIL rand_block got %h exp %h", b, e);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [511:0] s, e;
    s = rand_state();
    e = ref_block(s);
    send(s, lat);
    for (int k = 0; k < 50; k++) begin
      n_cmp++;
      if (out_block !== e || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold cyc %0d got %h v=%b exp %h v=1", k, out_block, out_valid, e);
      end
      n_cmp++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL bp_flags cyc %0d got rdy=%b busy=%b exp 0 0", k, in_ready, busy);
      end
      @(posedge g_clk);
      #1;
    end
    @(negedge g_clk) out_ready = 1'b1;
    @(posedge g_clk);
    #1 out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignored_input();
    int n;
    logic [511:0] b;
    @(negedge g_clk);
    in_state = rfc_state;
    in_valid = 1'b1;
    @(posedge g_clk);
    #1 in_valid = 1'b0;
    repeat (50) @(negedge g_clk);
    in_state = rand_state();
    in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL run_flags got rdy=%b busy=%b exp 0 1", in_ready, busy);
    end
    @(negedge g_clk) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 2000) begin
      @(posedge g_clk);
      #1 n++;
    end
    take(b);
    n_cmp++;
    if (b !== ref_block(rfc_state)) begin
      n_bad++; $display("FAIL ignored_block got %h exp %h", b, ref_block(rfc_state));
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [511:0] b;
    @(negedge g_clk);
    in_state = rand_state();
    in_valid = 1'b1;
    @(posedge g_clk);
    #1 in_valid = 1'b0;
    repeat (100) @(posedge g_clk);
    #1 g_resetn = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_block !== '0) begin
      n_bad++; $display("FAIL midreset_outputs got rdy=%b v=%b busy=%b blk=%h exp all 0",
                        in_ready, out_valid, busy, out_block);
    end
    @(negedge g_clk) g_resetn = 1'b1;
    send(rfc_state, lat);
    take(b);
    n_cmp++;
    if (b[31:0] !== 32'he4e7f110 || lat !== LAT) begin
      n_bad++; $display("FAIL midreset_rerun got w0=%h lat=%0d exp e4e7f110 %0d", b[31:0], lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int n, r1, r2;
    logic prev;
    logic [511:0] s, e, b1, b2;
    s = rand_state();
    e = ref_block(s);
    b1 = '0;
    b2 = '0;
    @(negedge g_clk);
    in_state  = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0; r1 = -1; r2 = -1; prev = 1'b0;
    while (r2 < 0 && n < 1500) begin
      @(posedge g_clk);
      #1 n++;
      if (out_valid && !prev) begin
        if (r1 < 0) begin
          r1 = n; b1 = out_block;
        end else begin
          r2 = n; b2 = out_block; in_valid = 1'b0;
        end
      end
      prev = out_valid;
    end
    in_valid = 1'b0;
    @(posedge g_clk);
    #1 out_ready = 1'b0;
    n_cmp++;
    if (r2 - r1 !== PERIOD) begin
      n_bad++; $display("FAIL b2b_period got %0d exp %0d", r2 - r1, PERIOD);
    end
    n_cmp++;
    if (b1 !== e || b2 !== e) begin
      n_bad++; $display("FAIL b2b_blocks got %h / %h exp %h", b1, b2, e);
    end
  endtask

`ifdef CHACHA_BLOCK_CTR_INC_EN
  task automatic send_next(output int lat);
    int n;
    n = 0;
    @(negedge g_clk);
    while (!in_ready && n < 2000) begin
      @(negedge g_clk);
      n++;
    end
    in_next = 1'b1;
    @(posedge g_clk);
    #1 in_next = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(posedge g_clk);
      #1 lat++;
    end
  endtask

  task automatic test_ctr_inc();
    int lat;
    logic [511:0] b, s, e;
    @(negedge g_clk) g_resetn = 1'b0;
    @(negedge g_clk) g_resetn = 1'b1;
    repeat (2) @(posedge g_clk);
    send_next(lat);
    take(b);
    e = ref_block(with_ctr('0, 32'd1));
    n_cmp++;
    if (b !== e) begin
      n_bad++; $display("FAIL ctr_from_zero got %h exp %h", b, e);
    end
    send(rfc_state, lat);
    take(b);
    send_next(lat);
    take(b);
    e = ref_block(with_ctr(rfc_state, 32'd2));
    n_cmp++;
    if (b !== e || lat !== LAT) begin
      n_bad++; $display("FAIL ctr_inc got %h lat %0d exp %h", b, lat, e);
    end
    s = with_ctr(rand_state(), 32'hffffffff);
    send(s, lat);
    take(b);
    send_next(lat);
    take(b);
    e = ref_block(with_ctr(s, 32'd0));
    n_cmp++;
    if (b !== e) begin
      n_bad++; $display("FAIL ctr_wrap got %h exp %h", b, e);
    end
    @(negedge g_clk);
    in_state = rfc_state;
    in_valid = 1'b1;
    in_next  = 1'b1;
    @(posedge g_clk);
    #1 in_valid = 1'b0;
    in_next = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(posedge g_clk);
      #1 lat++;
    end
    take(b);
    n_cmp++;
    if (b !== ref_block(rfc_state)) begin
      n_bad++; $display("FAIL ctr_valid_wins got %h exp %h", b, ref_block(rfc_state));
    end
  endtask
`endif

  initial begin
    logic [31:0] rw [16];
    rw = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
           32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
           32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
           32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    for (int i = 0; i < 16; i++) rfc_state[32*i +: 32] = rw[i];
    test_reset();
    test_rfc();
    test_random();
    test_backpressure();
    test_ignored_input();
    test_mid_reset();
    test_back_to_back();
`ifdef CHACHA_BLOCK_CTR_INC_EN
    test_ctr_inc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
